sccb_arbiter: RTL
=================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter DEV_ID, default 8'h42: SCCB write address driven on id.
REQ-002 Parameter GAP_CYCLES, default 16: idle holdoff in cycles after each transaction, minimum 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: cycles of send without taken before the request is aborted.
REQ-004 clk  in  1  core clock; the only clock.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 r0_valid / r1_valid  in  1  requester 0/1 has a register write pending.
REQ-007 r0_reg / r1_reg  in  8  target register address.
REQ-008 r0_value / r1_value  in  8  register data.
REQ-009 r0_ready / r1_ready  out  1  one-cycle accept pulse.
REQ-010 send  out  1  command strobe to the SCCB sender, held until taken.
REQ-011 id  out  8  device address, constant DEV_ID.
REQ-012 reg_addr / value  out  8 / 8  latched command fields.
REQ-013 taken  in  1  sender accepted the command (pulse).
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 grant_idx  out  1  index of the last granted requester.
REQ-016 timeout_err  out  1  one-cycle pulse when a command aborts.

Function
REQ-017 The block SHALL be a 3-state FSM: IDLE, ISSUE, GAP.
REQ-018 In IDLE, with any rN_valid high at edge N, the block SHALL latch that requester's reg/value into reg_addr/value, set grant_idx, pulse rN_ready and assert send, all visible in cycle N+1, and enter ISSUE.
REQ-019 If both valid are high in IDLE, the block SHALL grant the requester that is not grant_idx (round-robin); after reset requester 0 wins first.
REQ-020 Requesters SHALL hold valid, reg and value stable until ready; valid is not sampled outside IDLE.
REQ-021 In ISSUE, send SHALL stay high and reg_addr/value SHALL stay stable until taken is seen.
REQ-022 When taken is seen, send SHALL drop the next cycle, the gap counter SHALL load GAP_CYCLES-1, and the FSM SHALL enter GAP.
REQ-023 A timeout counter SHALL clear on entry to ISSUE and count each ISSUE cycle; on reaching TIMEOUT_CYCLES-1 without taken, send SHALL drop, timeout_err SHALL pulse once, and the FSM SHALL enter GAP.
REQ-024 If taken coincides with timeout expiry, the block SHALL treat it as taken and SHALL NOT pulse timeout_err.
REQ-025 In GAP, the counter SHALL decrement to 0; the FSM SHALL then return to IDLE and may grant in that same IDLE cycle.
REQ-026 taken in IDLE or GAP SHALL be ignored.
REQ-027 Each accepted request SHALL produce exactly one send assertion episode; there are no retries.
REQ-028 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-029 On reset_n low at a clk edge: state=IDLE, send=0, rN_ready=0, timeout_err=0, reg_addr=0, value=0, grant_idx=1, both counters=0, busy=0.
REQ-030 Reset mid-ISSUE or mid-GAP SHALL abandon the transaction, with no ready or error pulse; the aborted request is not replayed.

Structure
REQ-031 The state encoding, the DEV_ID default and the SCCB timing defaults SHALL live in shared package sccb_pkg.
REQ-032 The two-way round-robin selection SHALL be the sub-module sccb_rr_pick (combinational: valids plus last grant in, grant index out).

Verification
REQ-033 Single request: r0 reg=8'h12, value=8'h80; taken 5 cycles after send -> r0_ready one pulse, send high exactly 5 cycles, reg_addr=12, value=80, busy clears GAP_CYCLES cycles after send drops.
REQ-034 Contention: r0 and r1 valid together from reset -> r0 granted first and r1 next; then both re-raised -> r0 granted again (alternation).
REQ-035 Timeout with TIMEOUT_CYCLES=8 and taken held low -> send high 8 cycles, one timeout_err pulse, FSM returns to IDLE.
REQ-036 taken in the expiry cycle -> no timeout_err, normal GAP.
REQ-037 reset_n low during ISSUE -> next cycle send=0, busy=0, grant_idx=1, no ready or error pulse.
REQ-038 Spurious taken in IDLE and in GAP -> no state change, and the GAP length is unchanged.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: arbiter state encoding, device address and timing defaults.
package sccb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sccb_state_e;

  localparam logic [7:0] SCCB_DEV_ID          = 8'h42;
  localparam int         SCCB_GAP_CYCLES      = 16;
  localparam int         SCCB_TIMEOUT_CYCLES  = 65535;

endpackage

// File: rtl/sccb_rr_pick.sv
// Two-way round-robin pick: on contention the requester that did not win last time goes next.
module sccb_rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 1'b0;
    if (v0 && v1) begin
      grant = ~last;
    end else if (v1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Arbitrates two register-write requesters onto one SCCB sender, with a
// post-transaction holdoff and an abort if the sender never takes the command.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID         = SCCB_DEV_ID,
  parameter int         GAP_CYCLES     = SCCB_GAP_CYCLES,
  parameter int         TIMEOUT_CYCLES = SCCB_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r0_valid,
  input  logic [7:0] r0_reg,
  input  logic [7:0] r0_value,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [7:0] r1_reg,
  input  logic [7:0] r1_value,
  output logic       r1_ready,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] reg_addr,
  output logic [7:0] value,
  input  logic       taken,
  output logic       busy,
  output logic       grant_idx,
  output logic       timeout_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  sccb_state_e   state;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pick;

  sccb_rr_pick u_pick (
    .v0    (r0_valid),
    .v1    (r1_valid),
    .last  (grant_idx),
    .grant (pick)
  );

  assign id   = DEV_ID;
  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      send        <= 1'b0;
      r0_ready    <= 1'b0;
      r1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      reg_addr    <= '0;
      value       <= '0;
      grant_idx   <= 1'b1;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      r0_ready    <= 1'b0;
      r1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            grant_idx <= pick;
            reg_addr  <= pick ? r1_reg   : r0_reg;
            value     <= pick ? r1_value : r0_value;
            r0_ready  <= ~pick;
            r1_ready  <= pick;
            send      <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // taken wins over a simultaneous expiry, so it is tested first.
          if (taken) begin
            send    <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            send        <= 1'b0;
            timeout_err <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            state       <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
